apb_onread_regfile: RTL and testbench
=====================================

Name: apb_onread_regfile

Overview:
- APB slave register file: three 32-bit software-accessible registers with distinct read side effects.
  - REG1: onread=na (no side effect).
  - REG2: onread=rclr (read clears).
  - REG3: onread=rset (read sets).
- Combines the register-master bus front end and the leaf register block in one module.
- Each register has a hardware load port and exposes its current value to hardware.

Parameters:
- ADDR_WIDTH, 64, APB address width.
- DATA_WIDTH, 32, APB data width and register width.

Ports:
- PCLK  in  1  clock for bus and all registers.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PREADY  out  1  transfer complete.
- PRDATA  out  DATA_WIDTH  read data.
- PSLVERR  out  1  decode error.
- clear  in  1  interrupt clear; no interrupt sources exist, so it is ignored.
- interrupt  out  1  tied 0.
- soft_rst  in  1  synchronous soft reset, active-high.
- soft_rst_o  out  1  soft_rst forwarded combinationally to downstream blocks.
- REGn__FIELD_0__next_value  in  DATA_WIDTH  hardware load value, one per register (n = REG1_ONREAD_NA, REG2_ONREAD_RCLR, REG3_ONREAD_RSET).
- REGn__FIELD_0__pulse  in  1  hardware load strobe, one per register.
- REGn__FIELD_0__curr_value  out  DATA_WIDTH  current register value, one per register.

Behaviour:
- Address map, decoded on PADDR with bits [1:0] ignored; all other bits must match:
  - REG1 = 0x0
  - REG2 = 0x4
  - REG3 = 0x8
- Reset, asynchronous on PRESETn low:
  - all registers = 0x0000_0000
  - PREADY = 0, PSLVERR = 0, PRDATA = 0
  - internal FSM returns to IDLE.
- soft_rst high at a PCLK edge: registers load 0; bus FSM is unaffected.
- FSM states: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
  - IDLE: wait for PSEL=1 with PENABLE=0. Latch PADDR, PWRITE and PWDATA, then go to SETUP.
  - SETUP: wait for PSEL & PENABLE, then go to ACCESS. This is the one fixed wait state.
  - ACCESS: perform the register operation at this edge; assert PREADY (registered) for exactly one cycle; go to DONE.
  - DONE: PREADY=0; return to IDLE.
- PSEL=0 with PENABLE=1 (stale enable after a transfer) is ignored.
- Net timing: PREADY rises two cycles after the setup phase starts.
- PRDATA and PSLVERR are valid for the whole cycle in which PREADY=1. PRDATA = 0 otherwise.
- Write, on the edge entering PREADY=1: the addressed register loads PWDATA (full 32 bits, all fields RW).
- Read:
  - PRDATA = register value before any side effect.
  - Side effect at the same edge: REG1 unchanged; REG2 <- 0x0000_0000; REG3 <- 0xFFFF_FFFF.
- Unmapped address:
  - PSLVERR = 1 alongside PREADY.
  - PRDATA = 0.
  - No register changes.
- Hardware load: pulse=1 at an edge loads next_value into that register.
- Priority, highest first: soft_rst > software write/read side effect > hardware pulse (same register, same edge).
- curr_value outputs reflect the register flop directly, with no extra latency.

Test Plan:
- Reset, then read all three registers -> PRDATA = 0x0 each; REG2/REG3 then become 0x0 and 0xFFFFFFFF respectively.
- For each register, write 0x12345678 -> curr_value = 0x12345678 once PREADY completes.
- Read each register after that write:
  - PRDATA = 0x12345678 for all three.
  - curr_value after the read: REG1 = 0x12345678, REG2 = 0x00000000, REG3 = 0xFFFFFFFF.
- Write 0xFFFFFFFF to each register -> curr_value = 0xFFFFFFFF for all three.
- Assert pulse with next_value = 0xA5A5A5A5 on REG2 -> curr_value = 0xA5A5A5A5. Then issue a read on the same edge as a pulse on REG2 -> rclr wins and the result is 0.
- Access unmapped address 0x10 -> PSLVERR = 1 with PREADY, PRDATA = 0, registers unchanged.
- Assert soft_rst -> registers 0 and soft_rst_o = 1.
- Hold PSEL=0 with PENABLE=1 -> no transfer and no PREADY.

Source files
------------

// File: rtl/apb_onread_regfile.sv
// ============================================================================
// apb_onread_regfile: APB slave with three 32-bit registers (na / rclr / rset
// read side effects), hardware load ports and current-value outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_onread_regfile #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR,
  input  logic                  clear,
  output logic                  interrupt,
  input  logic                  soft_rst,
  output logic                  soft_rst_o,
  input  logic [DATA_WIDTH-1:0] REG1_ONREAD_NA__FIELD_0__next_value,
  input  logic                  REG1_ONREAD_NA__FIELD_0__pulse,
  output logic [DATA_WIDTH-1:0] REG1_ONREAD_NA__FIELD_0__curr_value,
  input  logic [DATA_WIDTH-1:0] REG2_ONREAD_RCLR__FIELD_0__next_value,
  input  logic                  REG2_ONREAD_RCLR__FIELD_0__pulse,
  output logic [DATA_WIDTH-1:0] REG2_ONREAD_RCLR__FIELD_0__curr_value,
  input  logic [DATA_WIDTH-1:0] REG3_ONREAD_RSET__FIELD_0__next_value,
  input  logic                  REG3_ONREAD_RSET__FIELD_0__pulse,
  output logic [DATA_WIDTH-1:0] REG3_ONREAD_RSET__FIELD_0__curr_value
);

  localparam int WW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e                state_q;
  logic [WW-1:0]         addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [DATA_WIDTH-1:0] reg1_q, reg2_q, reg3_q;
  logic [DATA_WIDTH-1:0] reg1_d, reg2_d, reg3_d;

  logic                  fire;
  logic                  hit1, hit2, hit3, hit_any;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  unused_ok;

  // Byte-lane bits and the interrupt clear carry no meaning for this block.
  assign unused_ok = ^{clear, PADDR[1:0]};

  assign fire    = (state_q == S_SETUP) && PSEL && PENABLE;
  assign hit1    = (addr_q == WW'(0));
  assign hit2    = (addr_q == WW'(1));
  assign hit3    = (addr_q == WW'(2));
  assign hit_any = hit1 | hit2 | hit3;

  always_comb begin
    rd_mux = '0;
    if (hit1) rd_mux = reg1_q;
    if (hit2) rd_mux = reg2_q;
    if (hit3) rd_mux = reg3_q;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          if (PSEL && !PENABLE) begin
            addr_q  <= PADDR[ADDR_WIDTH-1:2];
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (fire) begin
            pready_q  <= 1'b1;
            pslverr_q <= ~hit_any;
            prdata_q  <= (!write_q && hit_any) ? rd_mux : '0;
            state_q   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          state_q   <= S_DONE;
        end
        default: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  // A plain read of REG1 has no side effect, so a coincident pulse still lands.
  always_comb begin
    reg1_d = reg1_q;
    reg2_d = reg2_q;
    reg3_d = reg3_q;
    if (soft_rst)                        reg1_d = '0;
    else if (fire && hit1 && write_q)    reg1_d = wdata_q;
    else if (REG1_ONREAD_NA__FIELD_0__pulse)
                                         reg1_d = REG1_ONREAD_NA__FIELD_0__next_value;
    if (soft_rst)                        reg2_d = '0;
    else if (fire && hit2)               reg2_d = write_q ? wdata_q : '0;
    else if (REG2_ONREAD_RCLR__FIELD_0__pulse)
                                         reg2_d = REG2_ONREAD_RCLR__FIELD_0__next_value;
    if (soft_rst)                        reg3_d = '0;
    else if (fire && hit3)               reg3_d = write_q ? wdata_q : '1;
    else if (REG3_ONREAD_RSET__FIELD_0__pulse)
                                         reg3_d = REG3_ONREAD_RSET__FIELD_0__next_value;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      reg1_q <= '0;
      reg2_q <= '0;
      reg3_q <= '0;
    end else begin
      reg1_q <= reg1_d;
      reg2_q <= reg2_d;
      reg3_q <= reg3_d;
    end
  end

  assign PREADY     = pready_q;
  assign PSLVERR    = pslverr_q;
  assign PRDATA     = prdata_q;
  assign interrupt  = 1'b0;
  assign soft_rst_o = soft_rst;

  assign REG1_ONREAD_NA__FIELD_0__curr_value   = reg1_q;
  assign REG2_ONREAD_RCLR__FIELD_0__curr_value = reg2_q;
  assign REG3_ONREAD_RSET__FIELD_0__curr_value = reg3_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_onread_regfile.sv
// ============================================================================
// tb_apb_onread_regfile: directed plus randomized APB traffic checked against
// an array-based register model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_apb_onread_regfile;

  localparam int NA = 0, RCLR = 1, RSET = 2;

  logic        PCLK = 1'b0;
  logic        PRESETn, PSEL, PENABLE, PWRITE;
  logic [63:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic        clear, interrupt, soft_rst, soft_rst_o;
  logic [31:0] nv [3];
  logic [2:0]  pl;
  logic [31:0] cv [3];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m [3];
  int          onread [3] = '{NA, RCLR, RSET};

  always #5 PCLK = ~PCLK;

  apb_onread_regfile #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY),
    .PRDATA(PRDATA), .PSLVERR(PSLVERR), .clear(clear), .interrupt(interrupt),
    .soft_rst(soft_rst), .soft_rst_o(soft_rst_o),
    .REG1_ONREAD_NA__FIELD_0__next_value(nv[0]),
    .REG1_ONREAD_NA__FIELD_0__pulse(pl[0]),
    .REG1_ONREAD_NA__FIELD_0__curr_value(cv[0]),
    .REG2_ONREAD_RCLR__FIELD_0__next_value(nv[1]),
    .REG2_ONREAD_RCLR__FIELD_0__pulse(pl[1]),
    .REG2_ONREAD_RCLR__FIELD_0__curr_value(cv[1]),
    .REG3_ONREAD_RSET__FIELD_0__next_value(nv[2]),
    .REG3_ONREAD_RSET__FIELD_0__pulse(pl[2]),
    .REG3_ONREAD_RSET__FIELD_0__curr_value(cv[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 3; i++) chk($sformatf("%s_reg%0d", tag, i + 1), cv[i], m[i]);
  endtask

  // Reference: registers indexed by byte address / 4, side effects from the onread table.
  task automatic model_xfer(input bit wr, input logic [63:0] addr, input logic [31:0] wd,
                            input logic [2:0] pmask, output logic [31:0] er, output logic ee);
    longint unsigned word;
    int              idx;
    bit [2:0]        sw;
    word = addr / 4;
    sw   = '0;
    er   = '0;
    ee   = !(word < 3);
    if (word < 3) begin
      idx = int'(word);
      if (wr) begin
        m[idx] = wd;
        sw[idx] = 1'b1;
      end else begin
        er = m[idx];
        if (onread[idx] == RCLR) begin m[idx] = 32'h0; sw[idx] = 1'b1; end
        if (onread[idx] == RSET) begin m[idx] = 32'hFFFF_FFFF; sw[idx] = 1'b1; end
      end
    end
    for (int i = 0; i < 3; i++) if (pmask[i] && !sw[i]) m[i] = nv[i];
  endtask

  task automatic apb(input string tag, input bit wr, input logic [63:0] addr,
                     input logic [31:0] wd, input logic [2:0] pmask);
    logic [31:0] er, rd;
    logic        ee, err;
    bit          got;
    got = 1'b0; rd = '0; err = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; pl = pmask;
    @(posedge PCLK); #1;
    pl = '0;
    for (int n = 0; n < 8; n++) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) begin
        rd = PRDATA; err = PSLVERR; got = 1'b1;
        break;
      end
    end
    model_xfer(wr, addr, wd, pmask, er, ee);
    chk({tag, "_pready"}, {31'd0, got}, 32'd1);
    chk({tag, "_prdata"}, rd, er);
    chk({tag, "_pslverr"}, {31'd0, err}, {31'd0, ee});
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk({tag, "_pready_drop"}, {31'd0, PREADY}, 32'd0);
    chk_regs(tag);
  endtask

  task automatic pulse(input logic [2:0] pmask);
    @(posedge PCLK); #1;
    pl = pmask;
    @(posedge PCLK); #1;
    pl = '0;
    for (int i = 0; i < 3; i++) if (pmask[i]) m[i] = nv[i];
    chk_regs("pulse");
  endtask

  task automatic do_soft_rst(input logic [2:0] pmask);
    @(posedge PCLK); #1;
    soft_rst = 1'b1; pl = pmask;
    @(negedge PCLK);
    chk("soft_rst_o_hi", {31'd0, soft_rst_o}, 32'd1);
    @(posedge PCLK); #1;
    soft_rst = 1'b0; pl = '0;
    for (int i = 0; i < 3; i++) m[i] = 32'h0;
    chk_regs("soft_rst");
    chk("soft_rst_o_lo", {31'd0, soft_rst_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] addr_tab [7];
    addr_tab = '{64'h0, 64'h4, 64'h8, 64'h10, 64'h7, 64'hB, 64'h8000_0000_0000_0004};

    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; clear = 1'b0; soft_rst = 1'b0; pl = '0;
    for (int i = 0; i < 3; i++) begin nv[i] = '0; m[i] = '0; end
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_pready", {31'd0, PREADY}, 32'd0);
    chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_interrupt", {31'd0, interrupt}, 32'd0);
    chk_regs("rst");
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    for (int i = 0; i < 3; i++) apb("rd_after_rst", 1'b0, 64'(4 * i), 32'h0, 3'b000);
    for (int i = 0; i < 3; i++) apb("wr_1234", 1'b1, 64'(4 * i), 32'h1234_5678, 3'b000);
    for (int i = 0; i < 3; i++) apb("rd_1234", 1'b0, 64'(4 * i), 32'h0, 3'b000);
    for (int i = 0; i < 3; i++) apb("wr_ffff", 1'b1, 64'(4 * i), 32'hFFFF_FFFF, 3'b000);

    nv[1] = 32'hA5A5_A5A5;
    pulse(3'b010);
    apb("rd_vs_pulse", 1'b0, 64'h4, 32'h0, 3'b010);
    nv[0] = 32'h0BAD_F00D; nv[2] = 32'h3C3C_3C3C;
    apb("wr_vs_pulse", 1'b1, 64'h0, 32'hCAFE_0001, 3'b101);

    apb("unmapped_wr", 1'b1, 64'h10, 32'hDEAD_BEEF, 3'b000);
    apb("unmapped_rd", 1'b0, 64'h10, 32'h0, 3'b000);

    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 64'h0; PWDATA = 32'h5555_5555;
    for (int n = 0; n < 4; n++) begin
      @(negedge PCLK);
      chk("stale_en_pready", {31'd0, PREADY}, 32'd0);
    end
    @(posedge PCLK); #1;
    PENABLE = 1'b0;
    chk_regs("stale_en");

    do_soft_rst(3'b111);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 3; i++) nv[i] = $urandom;
      apb("rand", 1'($urandom_range(0, 1)), addr_tab[$urandom_range(0, 6)],
          $urandom, 3'($urandom_range(0, 7)));
      if (t == 20) do_soft_rst(3'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
